// File: rtl/ddr_multi_arbiter.sv
// N-channel DDR4 command arbiter with per-channel request latching and a watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module ddr_multi_arbiter #(
    parameter int                NUM_CH  = 4,
    parameter int                CH_W    = 2,
    parameter logic [NUM_CH-1:0] RD_MASK = NUM_CH'(4'b1010),
    parameter int                TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] start,
    output logic              busy,
    output logic [CH_W-1:0]   grant_id,
    output logic              mode,
    output logic [NUM_CH-1:0] pending,
    output logic              timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d, win;
    logic [NUM_CH-1:0] pend_q, start_q, start_d;
    logic              started_q;
    logic [15:0]       cnt_q;
    logic              to_hit;

`ifdef ARB_RR_EN
    logic [CH_W-1:0] last_q;
    logic            found;
    int              idx;

    // Search begins just after the previous winner and wraps around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last_q) + 1 + i) % NUM_CH;
            if (!found && pend_q[CH_W'(idx)]) begin
                win   = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= CH_W'(NUM_CH - 1);
        else if (state_q == IDLE && |pend_q)
            last_q <= win;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[CH_W'(i)])
                win = CH_W'(i);
        end
    end
`endif

    assign busy   = (state_q == BUSY);
    assign to_hit = busy && started_q && (TIMEOUT != 0) && (cnt_q == TO);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        start_d = '0;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = BUSY;
                    grant_d = win;
                end
            end
            BUSY: begin
                if (!started_q) begin
                    if (pend_q[grant_q])
                        start_d = NUM_CH'(1) << grant_q;
                end else if (done[grant_q] || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pend_q    <= '0;
            start_q   <= '0;
            started_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            start_q <= start_d;
            // A new request in the start cycle re-arms the bit being cleared.
            pend_q  <= (pend_q & ~start_d) | req;
            if (state_d == IDLE)
                started_q <= 1'b0;
            else if (|start_d)
                started_q <= 1'b1;
            if (busy && started_q && state_d == BUSY) begin
                if (cnt_q != 16'hFFFF)
                    cnt_q <= cnt_q + 16'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign start       = start_q;
    assign grant_id    = grant_q;
    assign pending     = pend_q;
    assign mode        = busy & RD_MASK[grant_q];
    assign timeout_err = to_hit & ~done[grant_q];

endmodule

// File: doc/ddr_multi_arbiter.md
# ddr_multi_arbiter

N-channel command arbiter for the PL DDR4 user interface. It replaces the fixed two-channel read/write arbiter and sits between the DMA/video request sources and the DDR4 command generators. The block latches request pulses per channel and grants one channel at a time. It issues a one-cycle start pulse to the winner, holds the grant until that channel's done, and drives the read/write mode mux. A watchdog frees the bus if done never arrives.

## Interface
- NUM_CH, 4: number of channels, 2..16.
- CH_W, 2: width of grant_id. Must be at least 1 and equal to ceil(log2(NUM_CH)).
- RD_MASK, 4'b1010: NUM_CH bits. Bit i = 1 marks channel i as a read channel.
- TIMEOUT, 1024: cycles allowed between start and done. 0 disables the watchdog. Maximum 65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_CH  per-channel request; pulse or level
- done  in  NUM_CH  per-channel transfer complete
- start  out  NUM_CH  one-hot, one-cycle command start pulse
- busy  out  1  high while a grant is held
- grant_id  out  CH_W  index of the granted channel
- mode  out  1  1 = granted channel is a read channel
- pending  out  NUM_CH  latched, unserviced requests
- timeout_err  out  1  one-cycle pulse when the watchdog fires

## Operation
- Reset values: all outputs are 0. State is IDLE. The watchdog counter is 0. last_grant resets to NUM_CH-1.
- pending[i] is set by req[i]=1.
  - It is cleared on the edge where start[i] is issued.
  - If req[i]=1 in that same cycle, set wins and the request stays pending.
  - A req to the active channel after its start is re-latched and serviced later.
- There are two states, IDLE and BUSY.
  - IDLE: when pending is nonzero, select a winner w. On the next edge go to BUSY and register grant_id=w.
  - BUSY, first cycle with pending[w]=1: on the next edge assert start[w] for one cycle and clear pending[w]. The block then sets its internal started flag.
  - BUSY with started=1: done[grant_id]=1 → IDLE on the next edge.
  - done on other channels is ignored. done before start is ignored.
- busy = 1 exactly when the state is BUSY.
- mode = busy & RD_MASK[grant_id].
- grant_id holds its value after returning to IDLE until the next grant.
- Watchdog (TIMEOUT>0):
  - A 16-bit counter runs while BUSY and started.
  - When it reaches TIMEOUT with no done: timeout_err pulses one cycle and the state goes to IDLE.
  - The timed-out channel is not re-pended automatically.
  - done in the timeout cycle takes priority: there is no error and normal completion applies.
- A reset assertion mid-transfer immediately clears the state, pending, start and counter. Requests in flight are dropped.

## Timing
- Request pulse at edge T (pending set at T+1) gives BUSY at T+2 and start at T+3.
- If req is sampled in IDLE at edge T (pending visible at T+1): BUSY at T+2, start at T+3.
- Done-to-next-start: done sampled at edge D gives IDLE at D+1, BUSY at D+2 and start at D+3. There is always at least one IDLE cycle between grants.
- start is never asserted in two consecutive cycles.
- At most one bit of start is set at any time.
- mode is valid from the BUSY entry edge, one cycle before start.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration. The search starts at (last_grant+1) mod NUM_CH and wraps.
  - last_grant updates on BUSY entry.
  - After reset, channel 0 has the highest priority.
- ARB_RR_EN undefined:
  - Fixed priority. The lowest pending index always wins.
  - last_grant is not implemented.

## Test plan
- Single request: req[2] pulsed at cycle 0 → pending=4'b0100 at 1, busy and grant_id=2 and mode=0 at 2, start=4'b0100 at 3 only, pending=0. done[2] at 10 → busy=0 at 11.
- Simultaneous: req=4'b1111 at cycle 0, each grant answered by done 3 cycles after start.
  - With ARB_RR_EN: start order is 0,1,2,3.
  - Re-pulsing req=4'b1111 after each done, with ARB_RR_EN: the order stays 0,1,2,3. Without ARB_RR_EN: channel 0 wins every time.
- Mode: grants to channels 1 and 3 → mode=1 throughout BUSY. Grants to channels 0 and 2 → mode=0.
- Re-request and stray done:
  - req[1] held in the start cycle and pulsed mid-transfer → pending[1]=1 after done, and channel 1 is serviced again.
  - done[0] during a grant to channel 1 → no state change.
- Watchdog: TIMEOUT=8, no done → timeout_err pulses exactly 8 cycles after start, then busy=0 next cycle. Done in the 8th cycle → no timeout_err.
- Reset mid-transfer: rst_n low while BUSY with pending=4'b1010 → all outputs are 0 asynchronously. After release, no start is issued until a new req.
